// File: rtl/pads_in_cond.sv
// -----------------------------------------------------------------------------
// pads_in_cond
//
// Conditions the raw core-side inputs from the input pad ring before the SoC
// uses them:
//   - buttons: SYNC_STAGES-flop synchroniser, per-bit debounce FSM, and
//     one-cycle press/release pulses on each accepted level change
//   - UART RX and SPI MISO: SYNC_STAGES-flop synchroniser only, no filtering
//
// Ports
//   clk            core clock (pad-ring clk_core)
//   rst_n          asynchronous active-low reset
//   btn_core       raw buttons from the pads (asynchronous, active-high)
//   uart_sin_core  raw UART RX from the pad (asynchronous, idles high)
//   spi_miso_core  raw SPI MISO from the pad (asynchronous)
//   btn_level      debounced button level
//   btn_press      one-cycle pulse on an accepted 0->1 transition
//   btn_release    one-cycle pulse on an accepted 1->0 transition
//   uart_sin_sync  synchronised UART RX
//   spi_miso_sync  synchronised SPI MISO
//
// Every output is driven directly by a flop; no input reaches an output
// through combinational logic.
// -----------------------------------------------------------------------------
module pads_in_cond #(
  parameter int BTN_W           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BTN_W-1:0] btn_core,
  input  logic             uart_sin_core,
  input  logic             spi_miso_core,
  output logic [BTN_W-1:0] btn_level,
  output logic [BTN_W-1:0] btn_press,
  output logic [BTN_W-1:0] btn_release,
  output logic             uart_sin_sync,
  output logic             spi_miso_sync
);

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } state_t;

  // Last count value before a pending level is accepted.
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(DEBOUNCE_CYCLES - 1);

  // True once the candidate level has been held long enough.
  function automatic logic cnt_at_cap(input logic [CNT_W-1:0] c);
    return (c == CNT_CAP);
  endfunction

  // Saturating increment: the counter never wraps past its cap.
  function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] c);
    return cnt_at_cap(c) ? c : c + CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Synchroniser stage: plain shift chains, element 0 samples the pad.
  // ---------------------------------------------------------------------------
  logic [BTN_W-1:0]       btn_chain [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] uart_chain;
  logic [SYNC_STAGES-1:0] spi_chain;
  logic [BTN_W-1:0]       btn_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        btn_chain[i] <= '0;
      end
      // UART line idles high, so reset the chain to the idle level to avoid
      // presenting a false start bit to the receiver.
      uart_chain <= '1;
      spi_chain  <= '0;
    end else begin
      btn_chain[0] <= btn_core;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        btn_chain[i] <= btn_chain[i-1];
      end
      uart_chain <= {uart_chain[SYNC_STAGES-2:0], uart_sin_core};
      spi_chain  <= {spi_chain[SYNC_STAGES-2:0], spi_miso_core};
    end
  end

  assign btn_sync      = btn_chain[SYNC_STAGES-1];
  assign uart_sin_sync = uart_chain[SYNC_STAGES-1];
  assign spi_miso_sync = spi_chain[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce stage: one independent STABLE/CHECK FSM per button bit.
  // ---------------------------------------------------------------------------
  state_t           state_q [BTN_W];
  state_t           state_d [BTN_W];
  logic [CNT_W-1:0] cnt_q   [BTN_W];
  logic [CNT_W-1:0] cnt_d   [BTN_W];
  logic [BTN_W-1:0] level_d;
  logic [BTN_W-1:0] press_d;
  logic [BTN_W-1:0] release_d;

  always_comb begin
    level_d   = btn_level;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < BTN_W; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        STABLE: begin
          if (btn_sync[i] != btn_level[i]) begin
            state_d[i] = CHECK;
            cnt_d[i]   = '0;
          end
        end
        CHECK: begin
          if (btn_sync[i] == btn_level[i]) begin
            // Bounced back to the accepted level: drop the candidate quietly.
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_at_cap(cnt_q[i])) begin
            level_d[i]   = btn_sync[i];
            press_d[i]   = btn_sync[i];
            release_d[i] = ~btn_sync[i];
            state_d[i]   = STABLE;
            cnt_d[i]     = '0;
          end else begin
            cnt_d[i] = cnt_inc_sat(cnt_q[i]);
          end
        end
        default: begin
          state_d[i] = STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: FSM state plus registered level and pulses.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTN_W; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      for (int i = 0; i < BTN_W; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
    end
  end

endmodule
